// File: rtl/hispi_lane_decoder.sv
// hispi_lane_decoder: HiSPi Packetized-SP receive decoder for one word-aligned lane.
// Finds 4-word sync sequences (all-ones, 0, 0, code), strips them from the stream
// and emits pixel words tagged with frame/line markers, plus line statistics and
// protocol error pulses.
// Ports:
//   sclk, sclk_reset_n         clock and asynchronous active-low reset
//   cfg_enable                 1 = decode, 0 = flush buffer and idle
//   cfg_line_pixels            expected pixels per line
//   in_valid, in_data          aligned lane words, no backpressure
//   pix_valid, pix_data        emitted pixel word
//   pix_sof/sol/eol/eof        pixel position tags, qualified by pix_valid
//   stat_pixel_count           pixels in the last terminated line
//   stat_line_count            lines in the last complete frame
//   err_line_length, err_sync  1-cycle error pulses
module hispi_lane_decoder #(
    parameter int PIXEL_WIDTH = 12,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   sclk,
    input  logic                   sclk_reset_n,
    input  logic                   cfg_enable,
    input  logic [CNT_WIDTH-1:0]   cfg_line_pixels,
    input  logic                   in_valid,
    input  logic [PIXEL_WIDTH-1:0] in_data,
    output logic                   pix_valid,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_sof,
    output logic                   pix_sol,
    output logic                   pix_eol,
    output logic                   pix_eof,
    output logic [CNT_WIDTH-1:0]   stat_pixel_count,
    output logic [CNT_WIDTH-1:0]   stat_line_count,
    output logic                   err_line_length,
    output logic                   err_sync
);
    typedef enum logic [1:0] {WAIT_SOF, IDLE_LINE, IN_LINE} state_t;

    state_t state_q, state_d;

    // Four-stage word buffer; index 0 is the newest word, index 3 the oldest.
    // Holding words back lets a preamble be dropped once its code word arrives.
    logic [3:0][PIXEL_WIDTH-1:0] b_dat;
    logic [3:0]                  b_vld, b_pix, b_sol, b_sof;
    logic                        arm_sol, arm_sof;
    logic [CNT_WIDTH-1:0]        pix_cnt, line_cnt;

    logic       preamble, is_code, legal, c_start, c_end, c_frame;
    logic       shift, code_ok, line_start, line_end, sync_err, emit;
    logic [CNT_WIDTH-1:0] line_pix;

    // Code bits: [2] marks a legal code, [1] frame-level (SOF/EOF), [0] end (EOL/EOF).
    assign preamble = &b_vld[2:0] && (b_dat[2] == {PIXEL_WIDTH{1'b1}})
                      && (b_dat[1] == '0) && (b_dat[0] == '0);
    assign is_code  = cfg_enable && in_valid && preamble;
    assign legal    = in_data[PIXEL_WIDTH-1];
    assign c_frame  = in_data[PIXEL_WIDTH-2];
    assign c_end    = in_data[PIXEL_WIDTH-3];
    assign c_start  = !c_end;
    assign code_ok  = is_code && legal;

    // State register
    always_ff @(posedge sclk or negedge sclk_reset_n) begin
        if (!sclk_reset_n)
            state_q <= WAIT_SOF;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!cfg_enable)
            state_d = WAIT_SOF;
        else if (code_ok)
            state_d = c_start ? ((state_q == WAIT_SOF && !c_frame) ? state_q : IN_LINE)
                              : ((state_q == IN_LINE) ? (c_frame ? WAIT_SOF : IDLE_LINE) : state_q);
    end

    // Control decode for the datapath
    always_comb begin
        shift      = cfg_enable && in_valid && !is_code;
        line_start = code_ok && c_start && (state_q != WAIT_SOF || c_frame);
        line_end   = code_ok && (state_q == IN_LINE);
        sync_err   = is_code && (!legal || (state_q == IDLE_LINE && c_end)
                                        || (state_q == IN_LINE && c_start));
        // Any legal code flushes s3; it only carries a pixel while inside a line,
        // so at most one pixel leaves per cycle.
        emit       = (shift || code_ok) && b_vld[3] && b_pix[3];
        line_pix   = (emit && !(&pix_cnt)) ? pix_cnt + CNT_WIDTH'(1) : pix_cnt;
    end

    // Datapath: buffer, output registers, counters
    always_ff @(posedge sclk or negedge sclk_reset_n) begin
        if (!sclk_reset_n) begin
            b_dat            <= '0;
            b_vld            <= '0;
            b_pix            <= '0;
            b_sol            <= '0;
            b_sof            <= '0;
            arm_sol          <= 1'b0;
            arm_sof          <= 1'b0;
            pix_valid        <= 1'b0;
            pix_data         <= '0;
            pix_sof          <= 1'b0;
            pix_sol          <= 1'b0;
            pix_eol          <= 1'b0;
            pix_eof          <= 1'b0;
            err_line_length  <= 1'b0;
            err_sync         <= 1'b0;
            pix_cnt          <= '0;
            line_cnt         <= '0;
            stat_pixel_count <= '0;
            stat_line_count  <= '0;
        end else if (!cfg_enable) begin
            b_vld           <= '0;
            arm_sol         <= 1'b0;
            arm_sof         <= 1'b0;
            pix_valid       <= 1'b0;
            pix_data        <= '0;
            pix_sof         <= 1'b0;
            pix_sol         <= 1'b0;
            pix_eol         <= 1'b0;
            pix_eof         <= 1'b0;
            err_line_length <= 1'b0;
            err_sync        <= 1'b0;
        end else begin
            pix_valid       <= emit;
            pix_data        <= emit ? b_dat[3] : '0;
            pix_sof         <= emit && b_sof[3];
            pix_sol         <= emit && b_sol[3];
            pix_eol         <= emit && code_ok;
            pix_eof         <= emit && code_ok && c_end && c_frame;
            err_sync        <= sync_err;
            err_line_length <= line_end && (line_pix != cfg_line_pixels);
            if (shift) begin
                b_dat   <= {b_dat[2:0], in_data};
                b_vld   <= {b_vld[2:0], 1'b1};
                b_pix   <= {b_pix[2:0], state_q == IN_LINE};
                b_sol   <= {b_sol[2:0], arm_sol};
                b_sof   <= {b_sof[2:0], arm_sof};
                arm_sol <= 1'b0;
                arm_sof <= 1'b0;
            end else if (is_code) begin
                // Preamble is dropped; s3 goes too once a legal code has flushed it.
                b_vld <= {b_vld[3] && !legal, 3'b000};
            end
            if (line_start) begin
                arm_sol <= 1'b1;
                arm_sof <= c_frame;
            end
            if (line_start)
                pix_cnt <= '0;
            else
                pix_cnt <= line_pix;
            if (line_end)
                stat_pixel_count <= line_pix;
            if (line_start && c_frame)
                line_cnt <= '0;
            else if (line_end)
                line_cnt <= line_cnt + CNT_WIDTH'(1);
            if (line_end && c_end && c_frame)
                stat_line_count <= line_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_hispi_lane_decoder.sv
// tb_hispi_lane_decoder: scoreboard bench for the HiSPi lane decoder.
module tb_hispi_lane_decoder;
    logic        sclk = 1'b0;
    logic        sclk_reset_n;
    logic        cfg_enable;
    logic [15:0] cfg_line_pixels;
    logic        in_valid;
    logic [11:0] in_data;
    logic        pix_valid, pix_sof, pix_sol, pix_eol, pix_eof;
    logic [11:0] pix_data;
    logic [15:0] stat_pixel_count, stat_line_count;
    logic        err_line_length, err_sync;

    int n_tests = 0;
    int n_fail  = 0;
    int n_sync  = 0;
    int n_len   = 0;

    // {data, sof, sol, eol, eof}
    logic [15:0] exp_q[$];

    localparam logic [11:0] SOL = 12'h800, SOF = 12'hC00, EOL = 12'hA00, EOF = 12'hE00;

    hispi_lane_decoder #(.PIXEL_WIDTH(12), .CNT_WIDTH(16)) dut (
        .sclk(sclk), .sclk_reset_n(sclk_reset_n), .cfg_enable(cfg_enable),
        .cfg_line_pixels(cfg_line_pixels), .in_valid(in_valid), .in_data(in_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_sol(pix_sol),
        .pix_eol(pix_eol), .pix_eof(pix_eof), .stat_pixel_count(stat_pixel_count),
        .stat_line_count(stat_line_count), .err_line_length(err_line_length),
        .err_sync(err_sync)
    );

    always #5 sclk = ~sclk;

    // Scoreboard monitor: every emitted pixel must match the head of the queue.
    always @(negedge sclk) begin
        if (sclk_reset_n === 1'b1) begin
            if (pix_valid === 1'b1) begin
                logic [15:0] e;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pixel got data=%h flags=%b%b%b%b required none",
                             pix_data, pix_sof, pix_sol, pix_eol, pix_eof);
                end else begin
                    e = exp_q.pop_front();
                    if ({pix_data, pix_sof, pix_sol, pix_eol, pix_eof} !== e) begin
                        n_fail++;
                        $display("FAIL pixel got data=%h flags=%b%b%b%b required data=%h flags=%b",
                                 pix_data, pix_sof, pix_sol, pix_eol, pix_eof, e[15:4], e[3:0]);
                    end
                end
            end
            if (err_sync === 1'b1) n_sync++;
            if (err_line_length === 1'b1) n_len++;
        end
    end

    task automatic send(input logic [11:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge sclk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sync(input logic [11:0] code);
        send(12'hFFF);
        send(12'h000);
        send(12'h000);
        send(code);
    endtask

    task automatic push(input logic [11:0] d, input logic sof, input logic sol,
                        input logic eol, input logic eof);
        exp_q.push_back({d, sof, sol, eol, eof});
    endtask

    // Sends n pixels base, base+1, ...; the first carries sol (and sof if asked),
    // the last carries the given end tags.
    task automatic line_px(input int n, input logic [11:0] base, input logic sof,
                           input logic eol, input logic eof);
        for (int i = 0; i < n; i++) begin
            logic [11:0] d;
            d = base + 12'(i);
            push(d, sof && i == 0, i == 0, eol && i == n - 1, eof && i == n - 1);
            send(d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic clear_errs;
        n_sync = 0;
        n_len  = 0;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({pix_valid, pix_sof, pix_sol, pix_eol, pix_eof, err_sync, err_line_length} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b required 0000000",
                     {pix_valid, pix_sof, pix_sol, pix_eol, pix_eof, err_sync, err_line_length});
        end
        n_tests++;
        if (pix_data !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_pix_data got %h required 000", pix_data);
        end
        n_tests++;
        if ({stat_pixel_count, stat_line_count} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stats got %h/%h required 0/0", stat_pixel_count, stat_line_count);
        end
    endtask

    task automatic test_frame;
        clear_errs();
        cfg_line_pixels = 16'd8;
        sync(SOF);
        line_px(8, 12'h001, 1'b1, 1'b1, 1'b0);
        sync(EOL);
        sync(SOL);
        line_px(8, 12'h009, 1'b0, 1'b1, 1'b1);
        sync(EOF);
        idle(3);
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL frame_drain got %0d pending required 0", exp_q.size());
        end
        n_tests++;
        if (stat_line_count !== 16'd2) begin
            n_fail++;
            $display("FAIL frame_lines got %0d required 2", stat_line_count);
        end
        n_tests++;
        if (stat_pixel_count !== 16'd8) begin
            n_fail++;
            $display("FAIL frame_pixels got %0d required 8", stat_pixel_count);
        end
        n_tests++;
        if (n_sync !== 0 || n_len !== 0) begin
            n_fail++;
            $display("FAIL frame_errors got sync=%0d len=%0d required 0/0", n_sync, n_len);
        end
    endtask

    task automatic test_latency_payload;
        logic [11:0] pat [7];
        pat = '{12'h111, 12'h222, 12'h333, 12'h444, 12'hFFF, 12'h000, 12'h123};
        clear_errs();
        cfg_line_pixels = 16'd7;
        sync(SOF);
        for (int i = 0; i < 7; i++) begin
            push(pat[i], i == 0, i == 0, i == 6, 1'b0);
            send(pat[i]);
            if (i == 3) begin
                n_tests++;
                if (pix_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latency_early got pix_valid=%b required 0", pix_valid);
                end
            end
            if (i == 4) begin
                n_tests++;
                if (pix_valid !== 1'b1 || pix_data !== 12'h111) begin
                    n_fail++;
                    $display("FAIL latency_first got valid=%b data=%h required 1/111",
                             pix_valid, pix_data);
                end
            end
        end
        sync(EOL);
        idle(3);
        n_tests++;
        if (exp_q.size() !== 0 || stat_pixel_count !== 16'd7) begin
            n_fail++;
            $display("FAIL payload got pending=%0d count=%0d required 0/7", exp_q.size(), stat_pixel_count);
        end
        n_tests++;
        if (n_sync !== 0 || n_len !== 0) begin
            n_fail++;
            $display("FAIL payload_errors got sync=%0d len=%0d required 0/0", n_sync, n_len);
        end
    endtask

    task automatic test_line_length;
        clear_errs();
        cfg_line_pixels = 16'd8;
        sync(SOL);
        line_px(7, 12'h020, 1'b0, 1'b1, 1'b0);
        sync(EOL);
        idle(3);
        n_tests++;
        if (n_len !== 1 || n_sync !== 0) begin
            n_fail++;
            $display("FAIL short_line_errors got len=%0d sync=%0d required 1/0", n_len, n_sync);
        end
        n_tests++;
        if (stat_pixel_count !== 16'd7 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL short_line got count=%0d pending=%0d required 7/0", stat_pixel_count, exp_q.size());
        end
    endtask

    task automatic test_empty_line;
        clear_errs();
        cfg_line_pixels = 16'd2;
        sync(SOL);
        sync(EOL);
        idle(2);
        n_tests++;
        if (stat_pixel_count !== 16'd0 || n_len !== 1) begin
            n_fail++;
            $display("FAIL empty_line got count=%0d len=%0d required 0/1", stat_pixel_count, n_len);
        end
        sync(SOF);
        line_px(2, 12'h030, 1'b1, 1'b1, 1'b1);
        sync(EOF);
        idle(3);
        n_tests++;
        if (stat_line_count !== 16'd1 || n_len !== 1 || n_sync !== 0 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL after_empty got lines=%0d len=%0d sync=%0d pending=%0d required 1/1/0/0",
                     stat_line_count, n_len, n_sync, exp_q.size());
        end
    endtask

    task automatic test_sol_in_line;
        clear_errs();
        cfg_line_pixels = 16'd4;
        sync(SOF);
        line_px(4, 12'h040, 1'b1, 1'b1, 1'b0);
        sync(SOL);
        line_px(3, 12'h050, 1'b0, 1'b1, 1'b1);
        sync(EOF);
        idle(3);
        n_tests++;
        if (n_sync !== 1 || n_len !== 1) begin
            n_fail++;
            $display("FAIL sol_in_line_errors got sync=%0d len=%0d required 1/1", n_sync, n_len);
        end
        n_tests++;
        if (stat_line_count !== 16'd2 || stat_pixel_count !== 16'd3 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sol_in_line got lines=%0d pixels=%0d pending=%0d required 2/3/0",
                     stat_line_count, stat_pixel_count, exp_q.size());
        end
    endtask

    task automatic test_illegal_code;
        clear_errs();
        cfg_line_pixels = 16'd4;
        sync(SOF);
        push(12'h061, 1'b1, 1'b1, 1'b0, 1'b0);
        send(12'h061);
        push(12'h062, 1'b0, 1'b0, 1'b0, 1'b0);
        send(12'h062);
        sync(12'h400);
        idle(2);
        n_tests++;
        if (n_sync !== 1) begin
            n_fail++;
            $display("FAIL illegal_code got sync=%0d required 1", n_sync);
        end
        push(12'h063, 1'b0, 1'b0, 1'b0, 1'b0);
        send(12'h063);
        push(12'h064, 1'b0, 1'b0, 1'b1, 1'b0);
        send(12'h064);
        sync(EOL);
        idle(3);
        n_tests++;
        if (n_sync !== 1 || n_len !== 0 || stat_pixel_count !== 16'd4 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL illegal_code_line got sync=%0d len=%0d count=%0d pending=%0d required 1/0/4/0",
                     n_sync, n_len, stat_pixel_count, exp_q.size());
        end
    endtask

    task automatic test_abort;
        clear_errs();
        cfg_line_pixels = 16'd3;
        sync(SOF);
        send(12'h0A1);
        send(12'h0A2);
        send(12'h0A3);
        #2 sclk_reset_n = 1'b0;
        #1;
        n_tests++;
        if ({pix_valid, stat_pixel_count, stat_line_count} !== 33'h0) begin
            n_fail++;
            $display("FAIL async_reset got valid=%b pixels=%0d lines=%0d required 0/0/0",
                     pix_valid, stat_pixel_count, stat_line_count);
        end
        idle(2);
        sclk_reset_n = 1'b1;
        sync(SOL);
        for (int i = 0; i < 4; i++) send(12'h0B0 + 12'(i));
        sync(EOL);
        idle(3);
        n_tests++;
        if (stat_pixel_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_no_sof got count=%0d required 0", stat_pixel_count);
        end
        sync(SOF);
        line_px(3, 12'h070, 1'b1, 1'b1, 1'b0);
        sync(EOL);
        sync(SOL);
        push(12'h081, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) send(12'h080 + 12'(i));
        cfg_enable = 1'b0;
        send(12'hFFF);
        n_tests++;
        if (pix_valid !== 1'b0 || stat_pixel_count !== 16'd3 || n_len !== 0) begin
            n_fail++;
            $display("FAIL disable got valid=%b count=%0d len=%0d required 0/3/0",
                     pix_valid, stat_pixel_count, n_len);
        end
        idle(1);
        cfg_enable = 1'b1;
        sync(SOL);
        for (int i = 0; i < 4; i++) send(12'h0C0 + 12'(i));
        sync(EOL);
        sync(SOF);
        line_px(3, 12'h090, 1'b1, 1'b1, 1'b1);
        sync(EOF);
        idle(3);
        n_tests++;
        if (exp_q.size() !== 0 || stat_line_count !== 16'd1 || n_sync !== 0) begin
            n_fail++;
            $display("FAIL recovery got pending=%0d lines=%0d sync=%0d required 0/1/0",
                     exp_q.size(), stat_line_count, n_sync);
        end
    endtask

    initial begin
        sclk_reset_n    = 1'b0;
        cfg_enable      = 1'b1;
        cfg_line_pixels = 16'd8;
        in_valid        = 1'b0;
        in_data         = 12'h0;
        idle(3);
        test_reset();
        sclk_reset_n = 1'b1;
        idle(2);
        test_reset();
        test_frame();
        test_latency_payload();
        test_line_length();
        test_empty_line();
        test_sol_in_line();
        test_illegal_code();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
